// File: rtl/nbit_logic_unit_pipe_if.sv
// Handshake and data bundle for the pipelined N-bit bitwise logic unit.
// The master drives operands and the downstream ready. The slave (the unit)
// drives in_ready, the result, the zero flag and the transaction counter.
interface nbit_logic_unit_pipe_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_zero;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out_data, out_zero, op_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out_data, out_zero, op_count
    );
endinterface

// File: rtl/nbit_logic_unit_pipe.sv
// Pipelined N-bit bitwise logic unit.
// - A 3-bit opcode selects one of eight bitwise functions of a and b.
// - The result and its zero flag pass through LATENCY register stages.
// - Valid/ready handshakes on both sides. The whole pipe stalls when the
//   output stage holds data that downstream does not take. Bubbles are
//   kept in the pipe, not collapsed.
// - Also keeps a count of accepted transactions that wraps at 2^CNT_W.
module nbit_logic_unit_pipe #(
    parameter int N       = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nbit_logic_unit_pipe_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic [LATENCY-1:0][N-1:0] r_data;
    logic [LATENCY-1:0]        r_zero;
    logic [LATENCY-1:0]        r_valid;
    logic [CNT_W-1:0]          r_count;

    logic                      w_adv;
    logic                      w_accept;
    logic [N-1:0]              w_result;

    // The pipe moves only when the output stage is empty or is being drained.
    assign w_adv    = !r_valid[LATENCY-1] | bus.out_ready;
    assign w_accept = bus.in_valid & w_adv;

    // Bitwise function select. An op of 000 or 111 ignores b.
    always_comb begin
        // NOTE: the default assignment first means every path assigns
        // w_result, so no latch is inferred even if the case is edited later.
        w_result = '0;
        unique case (op_e'(bus.op))
            OP_NOT:  w_result = ~bus.a;
            OP_AND:  w_result = bus.a & bus.b;
            OP_OR:   w_result = bus.a | bus.b;
            OP_XOR:  w_result = bus.a ^ bus.b;
            OP_NAND: w_result = ~(bus.a & bus.b);
            OP_NOR:  w_result = ~(bus.a | bus.b);
            OP_XNOR: w_result = ~(bus.a ^ bus.b);
            OP_PASS: w_result = bus.a;
            default: w_result = '0;
        endcase
    end

    // Pipeline stages. Stage 0 captures the new result, the later stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data and zero stages are cleared as well as the valid
            // bits, so out_data and out_zero read 0 while reset is held instead
            // of showing stale values.
            r_data  <= '0;
            r_zero  <= '0;
            r_valid <= '0;
        end else if (w_adv) begin
            // NOTE: non-blocking assignments make every stage sample the value
            // its neighbour held before this edge, so the loop order below does
            // not matter and the stages do not collapse into one.
            r_data[0]  <= w_result;
            r_zero[0]  <= (w_result == '0);
            r_valid[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_data[i]  <= r_data[i-1];
                r_zero[i]  <= r_zero[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Accepted-transaction counter. It wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_valid[LATENCY-1];
    assign bus.out_data  = r_data[LATENCY-1];
    assign bus.out_zero  = r_zero[LATENCY-1];
    assign bus.op_count  = r_count;

endmodule

// File: tb/tb_nbit_logic_unit_pipe.sv
// Self-checking bench for nbit_logic_unit_pipe.
// - One driver feeds four instances: N=8 with LATENCY 2, 1 and 4, and N=1.
//   The LATENCY=1 instance uses CNT_W=4 so that its counter wraps quickly.
// - Only the main instance (N=8, LATENCY=2) sees backpressure. The others
//   always have out_ready=1.
// - Inputs change 1 ns after the rising edge. Outputs are sampled on the
//   falling edge.
module tb_nbit_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       drv_valid = 1'b0;
    logic [2:0] drv_op = 3'b000;
    logic [7:0] drv_a = 8'h00;
    logic [7:0] drv_b = 8'h00;
    logic       drv_out_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nbit_logic_unit_pipe_if #(.N(8), .CNT_W(16)) bus2 ();
    nbit_logic_unit_pipe_if #(.N(8), .CNT_W(4))  bus1 ();
    nbit_logic_unit_pipe_if #(.N(8), .CNT_W(16)) bus4 ();
    nbit_logic_unit_pipe_if #(.N(1), .CNT_W(16)) busn ();

    assign bus2.in_valid = drv_valid;  assign bus2.op = drv_op;
    assign bus2.a = drv_a;             assign bus2.b = drv_b;
    assign bus2.out_ready = drv_out_ready;
    assign bus1.in_valid = drv_valid;  assign bus1.op = drv_op;
    assign bus1.a = drv_a;             assign bus1.b = drv_b;
    assign bus1.out_ready = 1'b1;
    assign bus4.in_valid = drv_valid;  assign bus4.op = drv_op;
    assign bus4.a = drv_a;             assign bus4.b = drv_b;
    assign bus4.out_ready = 1'b1;
    assign busn.in_valid = drv_valid;  assign busn.op = drv_op;
    assign busn.a = drv_a[0];          assign busn.b = drv_b[0];
    assign busn.out_ready = 1'b1;

    nbit_logic_unit_pipe #(.N(8), .LATENCY(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    nbit_logic_unit_pipe #(.N(8), .LATENCY(1), .CNT_W(4)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    nbit_logic_unit_pipe #(.N(8), .LATENCY(4), .CNT_W(16)) dut_l4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    nbit_logic_unit_pipe #(.N(1), .LATENCY(2), .CNT_W(16)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .bus(busn.slave));

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Check one N=8 output stage against the vector table for cycle c.
    task automatic chk_out(input string tag, input int lat, input int c,
                           input logic v, input logic [7:0] d, input logic z);
        int idx;
        idx = c - lat;
        if (idx >= 0 && idx < 10) begin
            check($sformatf("%s valid c%0d", tag, c), 32'(v), 32'd1);
            check($sformatf("%s data c%0d", tag, c), 32'(d), 32'(vecs[idx].exp));
            check($sformatf("%s zero c%0d", tag, c), 32'(z), 32'(vecs[idx].exp == 8'h00));
        end else begin
            check($sformatf("%s idle c%0d", tag, c), 32'(v), 32'd0);
        end
    endtask

    task automatic do_reset();
        drv_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        drv_valid = v;
        drv_op    = op;
        drv_a     = a;
        drv_b     = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3'b000, 8'hA5, 8'h0F, 8'h5A};
        vecs[1] = '{3'b001, 8'hA5, 8'h0F, 8'h05};
        vecs[2] = '{3'b010, 8'hA5, 8'h0F, 8'hAF};
        vecs[3] = '{3'b011, 8'hA5, 8'h0F, 8'hAA};
        vecs[4] = '{3'b100, 8'hA5, 8'h0F, 8'hFA};
        vecs[5] = '{3'b101, 8'hA5, 8'h0F, 8'h50};
        vecs[6] = '{3'b110, 8'hA5, 8'h0F, 8'h55};
        vecs[7] = '{3'b111, 8'hA5, 8'h0F, 8'hA5};
        vecs[8] = '{3'b001, 8'hF0, 8'h0F, 8'h00};
        vecs[9] = '{3'b110, 8'h3C, 8'h3C, 8'hFF};

        // Reset state while rst_n is held low.
        #2;
        check("rst out_valid", 32'(bus2.out_valid), 32'd0);
        check("rst out_data", 32'(bus2.out_data), 32'd0);
        check("rst out_zero", 32'(bus2.out_zero), 32'd0);
        check("rst op_count", 32'(bus2.op_count), 32'd0);
        check("rst in_ready", 32'(bus2.in_ready), 32'd1);
        #6 rst_n = 1'b1;

        // Stream the table back to back on every instance.
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (c < 10) drive(1'b1, vecs[c].op, vecs[c].a, vecs[c].b);
            else        drive(1'b0, 3'b000, 8'h00, 8'h00);
            @(negedge clk);
            check($sformatf("ops in_ready c%0d", c), 32'(bus2.in_ready), 32'd1);
            chk_out("L2", 2, c, bus2.out_valid, bus2.out_data, bus2.out_zero);
            chk_out("L1", 1, c, bus1.out_valid, bus1.out_data, bus1.out_zero);
            chk_out("L4", 4, c, bus4.out_valid, bus4.out_data, bus4.out_zero);
            if (c >= 2 && c < 12) begin
                check($sformatf("N1 data c%0d", c), 32'(busn.out_data), 32'(vecs[c-2].exp[0]));
                check($sformatf("N1 zero c%0d", c), 32'(busn.out_zero), 32'(!vecs[c-2].exp[0]));
            end
            if (c == 8) check("ops op_count after 8", 32'(bus2.op_count), 32'd8);
        end
        check("ops op_count end", 32'(bus2.op_count), 32'd10);

        // Backpressure: 4 transactions, out_ready low for cycles 2..4.
        do_reset();
        begin
            logic [7:0] src_a [4];
            logic [7:0] exp_q [$];
            int sent;
            int got;
            logic accepted;
            src_a = '{8'h11, 8'h22, 8'h33, 8'h44};
            sent = 0;
            got = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                #1;
                drv_out_ready = !(c >= 2 && c <= 4);
                if (sent < 4) drive(1'b1, 3'b011, src_a[sent], 8'h0F);
                else          drive(1'b0, 3'b000, 8'h00, 8'h00);
                @(negedge clk);
                if (c >= 2 && c <= 4) begin
                    check($sformatf("bp in_ready stall c%0d", c), 32'(bus2.in_ready), 32'd0);
                    check($sformatf("bp hold valid c%0d", c), 32'(bus2.out_valid), 32'd1);
                    check($sformatf("bp hold data c%0d", c), 32'(bus2.out_data), 32'h1E);
                end
                accepted = drv_valid && bus2.in_ready;
                if (accepted) begin
                    exp_q.push_back(src_a[sent] ^ 8'h0F);
                    sent++;
                end
                if (bus2.out_valid && drv_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("bp extra output c%0d", c), 32'(bus2.out_data), 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("bp order %0d", got), 32'(bus2.out_data), 32'(exp_q.pop_front()));
                        got++;
                    end
                end
                if (got == 4 && c >= 10) break;
            end
            drv_out_ready = 1'b1;
            check("bp outputs seen", 32'(got), 32'd4);
            check("bp op_count", 32'(bus2.op_count), 32'd4);
        end

        // Bubbles: valid, idle, valid.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 0)      drive(1'b1, 3'b111, 8'h01, 8'h00);
            else if (c == 2) drive(1'b1, 3'b111, 8'h02, 8'h00);
            else             drive(1'b0, 3'b000, 8'h00, 8'h00);
            @(negedge clk);
            if (c == 2 || c == 4) begin
                check($sformatf("bub valid c%0d", c), 32'(bus2.out_valid), 32'd1);
                check($sformatf("bub data c%0d", c), 32'(bus2.out_data), (c == 2) ? 32'h01 : 32'h02);
            end else begin
                check($sformatf("bub idle c%0d", c), 32'(bus2.out_valid), 32'd0);
            end
        end
        check("bub op_count", 32'(bus2.op_count), 32'd2);

        // Asynchronous reset with two transactions in flight.
        do_reset();
        @(posedge clk); #1 drive(1'b1, 3'b111, 8'h77, 8'h00);
        @(posedge clk); #1 drive(1'b1, 3'b111, 8'h88, 8'h00);
        @(posedge clk); #1 drive(1'b0, 3'b000, 8'h00, 8'h00);
        check("mid pre valid", 32'(bus2.out_valid), 32'd1);
        check("mid pre data", 32'(bus2.out_data), 32'h77);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(bus2.out_valid), 32'd0);
        check("mid rst out_data", 32'(bus2.out_data), 32'd0);
        check("mid rst op_count", 32'(bus2.op_count), 32'd0);
        check("mid rst in_ready", 32'(bus2.in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) drive(1'b1, 3'b000, 8'h00, 8'h00);
            else        drive(1'b0, 3'b000, 8'h00, 8'h00);
            @(negedge clk);
            if (c < 2) begin
                check($sformatf("post idle c%0d", c), 32'(bus2.out_valid), 32'd0);
            end else begin
                check("post valid", 32'(bus2.out_valid), 32'd1);
                check("post data", 32'(bus2.out_data), 32'hFF);
                check("post zero", 32'(bus2.out_zero), 32'd0);
                check("post op_count", 32'(bus2.op_count), 32'd1);
            end
        end

        // Counter wrap on the CNT_W=4 instance.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 3'b111, 8'(i), 8'h00);
            @(negedge clk);
            if (i == 16) check("wrap cnt4 at 16", 32'(bus1.op_count), 32'd0);
        end
        @(posedge clk);
        #1 drive(1'b0, 3'b000, 8'h00, 8'h00);
        @(negedge clk);
        check("wrap cnt4 at 17", 32'(bus1.op_count), 32'd1);
        check("wrap cnt16 at 17", 32'(bus2.op_count), 32'd17);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nbit_logic_unit_pipe.md
Name: nbit_logic_unit_pipe

Overview:
- Parametrised, pipelined N-bit bitwise logic unit. It is the successor to the single-function structural N-bit inverter.
- A 3-bit opcode selects one of eight bitwise functions of two N-bit operands.
- The result travels through a LATENCY-stage register pipeline with a valid/ready handshake on both sides and full backpressure.
- It sits beside the adder/ALU datapath blocks as the logic-operation slice and also reports a zero flag and a transaction counter.

Parameters:
- N, 32, operand/result width in bits (N >= 1).
- LATENCY, 2, number of register stages from input acceptance to output (1..4).
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept this cycle.
- op  input  3  function select.
- a  input  N  operand A.
- b  input  N  operand B.
- out_valid  output  1  out_data and out_zero are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  N  registered result.
- out_zero  output  1  1 when out_data == 0.
- op_count  output  CNT_W  number of accepted input transactions, modulo 2^CNT_W.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0, immediately and regardless of clk:
  - every stage valid bit = 0 and every stage data/zero register = 0;
  - out_valid=0, out_data=0, out_zero=0, op_count=0.
  - in_ready is 1 once reset is asserted, because out_valid=0.
- Op encoding, evaluated bitwise on all N bits:
  - 000 ~a; 001 a&b; 010 a|b; 011 a^b;
  - 100 ~(a&b); 101 ~(a|b); 110 ~(a^b); 111 a (pass).
  - For op 000 and op 111, b is ignored.
- Advance and handshake:
  - adv = !out_valid | out_ready; in_ready = adv (combinational).
  - Accept = in_valid & in_ready. The source must hold in_valid/op/a/b stable until accepted.
- Stage 1 on adv: captures result = f(op,a,b), zero = (result==0), valid = accept.
- Stages 2..LATENCY on adv: copy the previous stage, including its valid bit.
- Outputs: out_valid, out_data and out_zero come from the last stage.
- When adv=0 the whole pipeline holds. Output data, valid and zero stay stable while out_valid=1 & out_ready=0.
- Latency:
  - A transaction accepted at edge k appears with out_valid=1 after edge k+LATENCY-1, i.e. LATENCY cycles after the input cycle, provided adv stays 1.
  - Throughput is 1 per cycle while out_ready=1.
- Bubbles (cycles with in_valid=0) propagate as valid=0 stages. They are not collapsed, so a stall stalls the entire pipe.
- out_zero is computed in stage 1 and pipelined; it is never recomputed from out_data.
- op_count increments by 1 on every accept edge and wraps from 2^CNT_W-1 to 0. It never changes on a stall.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle is legal.
  - With out_valid=1 & out_ready=0, in_ready=0 and in_valid is ignored.
- Reset mid-operation: all in-flight transactions are discarded and op_count is cleared. After release, the first accept behaves as from cold.
- LATENCY=1: stage 1 is the output stage.
- N=1 must elaborate and operate correctly.

Test Plan:
- N=8, LATENCY=2, out_ready=1. Stream a=A5, b=0F with op 0..7 on consecutive cycles. Required outputs in order: 5A, 05, AF, AA, FA, 50, 55, A5, each exactly 2 cycles after its input, out_zero=0, op_count=8 at the end.
- op=001, a=F0, b=0F -> out_data=00, out_zero=1. Then op=110, a=3C, b=3C -> FF, out_zero=0.
- Backpressure: stream 4 transactions and drop out_ready for 3 cycles while out_valid=1.
  - in_ready must be 0 during the stall.
  - out_data must be held.
  - No transaction is lost or duplicated; order is preserved.
  - op_count=4 at the end.
- Bubbles: valid, idle, valid inputs -> outputs valid, invalid, valid with matching spacing, and op_count=2.
- Reset mid-stream: assert rst_n=0 asynchronously (between edges) with 2 transactions in flight.
  - out_valid, out_data and op_count go to 0 immediately.
  - After release, op=000, a=00 produces FF as the first output.
- CNT_W=4: accept 17 transactions -> op_count wraps through 0 and reads 1. Repeat the ops test with LATENCY=1 and LATENCY=4: identical data with latency 1 and 4 respectively.
